div_hilo_ctrl: RTL

//  Sequencer between the CPU execute stage and the shared 32-iteration signed divider.
//  - Accepts DIV requests and pulses the divider start for exactly one cycle.
//  - Waits for the divider done strobe, then commits quotient to LO and remainder to HI.
//  - Owns the HI/LO registers and serves MTHI/MTLO writes.
//  - Stalls the pipeline while a division is in flight.

---
 rtl/div_hilo_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/div_hilo_ctrl.sv
// Sequences DIV requests through the shared signed divider and owns the HI/LO registers (MTHI/MTLO writes).
// Optional build macro DIV_ZERO_TRAP_EN turns zero-divisor DIVs into a div_zero_exc pulse instead of the fixed result.
module div_hilo_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int TIMEOUT    = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_div,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_busy,
    input  logic        div_over,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
`ifdef DIV_ZERO_TRAP_EN
    output logic        div_zero_exc,
`endif
    output logic        done
);

    // Wide enough to count past both the expected divide length and the abort limit.
    localparam int WD_W = $clog2(TIMEOUT + DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       dvd_q, dvd_d;
    logic [31:0]       dvs_q, dvs_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              done_q, done_d;
`ifdef DIV_ZERO_TRAP_EN
    logic              exc_q, exc_d;
`endif

    // Divider busy carries no control meaning here; an early drop in WAIT is tolerated.
    logic unused_div_busy;
    assign unused_div_busy = div_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
`ifdef DIV_ZERO_TRAP_EN
            exc_q   <= exc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        wd_d      = wd_q;
        done_d    = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        exc_d     = 1'b0;
`endif
        div_start = 1'b0;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                stall = op_div;
                if (op_div) begin
                    if (rt_val != 32'd0) begin
                        dvd_d   = rs_val;
                        dvs_d   = rt_val;
                        state_d = ISSUE;
                    end else begin
`ifdef DIV_ZERO_TRAP_EN
                        exc_d  = 1'b1;
`else
                        // Zero divisor bypasses the divider with a fixed result.
                        hi_d   = rs_val;
                        lo_d   = 32'hFFFF_FFFF;
                        done_d = 1'b1;
`endif
                    end
                end else begin
                    if (op_mthi) hi_d = rs_val;
                    if (op_mtlo) lo_d = rs_val;
                end
            end
            ISSUE: begin
                stall     = 1'b1;
                div_start = 1'b1;
                wd_d      = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (div_over) begin
                    lo_d    = div_q;
                    hi_d    = div_r;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign done         = done_q;
`ifdef DIV_ZERO_TRAP_EN
    assign div_zero_exc = exc_q;
`endif

endmodule
